bfii: RTL
=========

# bfii

Radix-2² single-delay-feedback (SDF) second butterfly stage (BF-II) of the streaming FFT pipeline. Sits directly downstream of the BF-I stage of the same `STAGE` index and consumes its complex sample stream. It applies the trivial −j rotation and a radix-2 add/subtract through a feedback delay of half BF-I's depth, then feeds the twiddle multiplier. It generates its own control bits from an internal sample counter, so no external control wiring is needed.

## Interface
- `DATA_WIDTH`, 16: signed two's-complement width of each real/imag component.
- `N_POINTS`, 16: FFT length; power of 2, ≥4.
- `STAGE`, 0: radix-2² stage index; `BUF_SIZE = N_POINTS >> (2*STAGE+2)`, ≥1.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: global clock enable; 0 freezes all state and outputs.
- `clr` in 1: synchronous frame restart.
- `in_val` in 1: input sample valid.
- `a_re` in `DATA_WIDTH`: real part of input sample.
- `a_im` in `DATA_WIDTH`: imaginary part of input sample.
- `b_val` out 1: output sample valid.
- `b_re` out `DATA_WIDTH`: real part of output sample.
- `b_im` out `DATA_WIDTH`: imaginary part of output sample.

## Operation
- Accept = `en & in_val & ~clr`.
- Sample counter `cnt` is `log2(4*BUF_SIZE)` bits and increments on accept; it wraps at `4*BUF_SIZE`.
- Control bits: `s = cnt[LB]`, `t = cnt[LB+1]`, where `LB = log2(BUF_SIZE)`.
- Delay line: `BUF_SIZE` complex entries at pointer `p = cnt[LB-1:0]`. The same address is read and written on each accept. For `BUF_SIZE=1`, `p` is a constant 0 and the pointer logic has zero width.
- Rotation: when `s & t`, the input becomes `x = (a_im, −a_re)` (multiply by −j). Otherwise `x = a`.
- Phase `s=0` (fill): write `buf[p] <= x`; output `buf[p]`.
- Phase `s=1` (butterfly): output `x + buf[p]`; write `buf[p] <= x − buf[p]`.
- Arithmetic: computed at `DATA_WIDTH+1` bits, then reduced per Configuration. −a_re is also computed at `DATA_WIDTH+1` bits, so −(−2^(W−1)) is exact before reduction.
- `primed` flag: set on the accept where `cnt == BUF_SIZE−1`; thereafter stays set.
- `b_val` is set to `accept & primed_before_this_accept`. The first `BUF_SIZE` accepts after reset or `clr` give no valid output.
- Frames are continuous. A frame's last `BUF_SIZE` differences are emitted by the next frame's first `BUF_SIZE` accepts.
- `clr` (when `en`): `cnt <= 0`, `primed <= 0`, `b_val <= 0`. The input sample is dropped and buffer contents are kept.
- `en=1, in_val=0`: `b_val <= 0`; `b_re`/`b_im`, counter and buffer hold.
- `rst`: `cnt`, `primed` and all buffer entries go to 0. Outputs reset to `b_val=0`, `b_re=0`, `b_im=0`. Reset mid-frame fully discards the frame.

## Timing
- All outputs are registered.
- Output appears one clock after the accepting edge.
- Sum outputs: latency 1 cycle.
- Difference outputs: emitted on the `BUF_SIZE`-th accept after the one that formed them.
- No backpressure; the consumer must take every `b_val` beat.
- Throughput is one sample per clock.

## Configuration
- `BFII_SCALE_EN` defined: every sum and difference is arithmetically shifted right by 1 (floor) from the `DATA_WIDTH+1` result. This applies to values written to the buffer and to values output. Fill-phase writes are unscaled.
- `BFII_SCALE_EN` undefined: results are truncated to the low `DATA_WIDTH` bits (wrap-around).

## Structure
- Shared package `fft_pkg` holds:
  - `cplx_t` struct `{re, im}`, parameterised via `DATA_WIDTH`;
  - `function fft_buf_size(n, stage, radix_half)`;
  - counter-width helper handling `BUF_SIZE=1`.
- Sub-module `fft_delay_line`: `BUF_SIZE`-deep complex circular register file with a shared read/write pointer and async-reset clear. It is reusable by BF-I.

## Test plan
- Config: `N=16`, `STAGE=0` (`BUF=4`), macro off. Stimulus: 16 accepts, `a=(k,0)` for k=0..15, then 4 zero samples. Required outputs, in order:
  - (4,0), (6,0), (8,0), (10,0);
  - (4,0) ×4;
  - (8,−12), (9,−13), (10,−14), (11,−15);
  - (−8,−12), (−9,−13), (−10,−14), (−11,−15).
  - `b_val` is 0 for the first 4 accepts.
- Overflow: fill `a_re=0x0001`, butterfly input `a_re=0x7FFF`. Required: `b_re=0x8000` with macro off; `b_re=0x4000` with `BFII_SCALE_EN`.
- Rotation edge: at `s&t` with `a=(0,−32768)`, macro on, buffer 0. Required: output (−16384, 0).
- Stall: `in_val` toggled 1/0 each cycle through the first test. Required: same output sequence; `b_val` is 0 on idle cycles; output registers hold between beats.
- `clr`: assert after 6 accepts, then restart the first test's stimulus. Required: first 4 post-`clr` accepts give `b_val=0`, and the sequence matches the first test.
- Async reset mid-frame: `rst` pulse between edges. Required: outputs go to 0 immediately; the next frame matches the first test, with the initial four (4,0) outputs unaffected by stale buffer data.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT pipeline types and elaboration helpers: complex sample type,
// per-stage delay-buffer sizing and pointer-width calculation.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 16;

    // Default-width complex sample; stages of another width declare their own.
    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } cplx_t;

    function automatic int unsigned fft_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // radix_half selects the BF-II buffer, which is half the BF-I depth.
    function automatic int unsigned fft_buf_size(input int unsigned n, input int unsigned stage,
                                                 input bit radix_half);
        return n >> (2 * stage + (radix_half ? 2 : 1));
    endfunction

    // A single-entry buffer needs no pointer; keep one dummy bit so ports stay legal.
    function automatic int unsigned fft_ptr_w(input int unsigned buf_size);
        return (buf_size > 1) ? fft_clog2(buf_size) : 1;
    endfunction

endpackage

// File: rtl/bfii_if.sv
// Sample stream bundle between the BF-I stage, BF-II and the twiddle multiplier.
interface bfii_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_val;
    logic [DATA_WIDTH-1:0] a_re;
    logic [DATA_WIDTH-1:0] a_im;
    logic                  b_val;
    logic [DATA_WIDTH-1:0] b_re;
    logic [DATA_WIDTH-1:0] b_im;

    modport master (output in_val, a_re, a_im, input b_val, b_re, b_im);
    modport slave  (input in_val, a_re, a_im, output b_val, b_re, b_im);
endinterface

// File: rtl/fft_delay_line.sv
// Complex circular register file with one shared read/write pointer and async clear.
// Reads are combinational from the current pointer; writes land on the clock edge.
module fft_delay_line #(
    parameter int unsigned DataWidth = 16,
    parameter int unsigned Depth     = 4,
    parameter int unsigned PtrW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_i,
    input  logic [PtrW-1:0]      ptr_i,
    input  logic [DataWidth-1:0] wdata_re_i,
    input  logic [DataWidth-1:0] wdata_im_i,
    output logic [DataWidth-1:0] rdata_re_o,
    output logic [DataWidth-1:0] rdata_im_o
);
    logic [DataWidth-1:0] mem_re_q [Depth];
    logic [DataWidth-1:0] mem_im_q [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < Depth; i++) begin
                if (Depth == 1 || ptr_i == PtrW'(i)) begin
                    mem_re_q[i] <= wdata_re_i;
                    mem_im_q[i] <= wdata_im_i;
                end
            end
        end
    end

    generate
        if (Depth == 1) begin : g_single
            assign rdata_re_o = mem_re_q[0];
            assign rdata_im_o = mem_im_q[0];
        end else begin : g_multi
            assign rdata_re_o = mem_re_q[ptr_i];
            assign rdata_im_o = mem_im_q[ptr_i];
        end
    endgenerate

endmodule

// File: rtl/bfii.sv
// Radix-2^2 SDF BF-II stage: -j rotation plus radix-2 butterfly through a feedback delay.
// Define BFII_SCALE_EN to halve every sum/difference instead of wrapping to DATA_WIDTH bits.
module bfii
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N_POINTS   = 16,
    parameter int unsigned STAGE      = 0
) (
    input logic  clk,
    input logic  rst,
    input logic  en_i,
    input logic  clr_i,
    bfii_if.slave bus_io
);
    localparam int unsigned BufSize = fft_buf_size(N_POINTS, STAGE, 1'b1);
    localparam int unsigned Lb      = fft_clog2(BufSize);
    localparam int unsigned CntW    = Lb + 2;
    localparam int unsigned PtrW    = fft_ptr_w(BufSize);
    localparam int unsigned W       = DATA_WIDTH;

    logic            accept;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            primed_q, primed_d;
    logic            s_ph, t_ph, rot;
    logic [PtrW-1:0] ptr;

    logic [W-1:0] m_re, m_im, wr_re, wr_im, out_re, out_im;
    logic [W-1:0] sum_re_r, sum_im_r, dif_re_r, dif_im_r;
    logic signed [W:0] a_re_x, a_im_x, m_re_x, m_im_x, x_re, x_im;
    logic signed [W:0] sum_re, sum_im, dif_re, dif_im;

    logic         b_val_q, b_val_d;
    logic [W-1:0] b_re_q, b_re_d, b_im_q, b_im_d;

    assign accept = en_i & bus_io.in_val & ~clr_i;
    assign s_ph   = cnt_q[Lb];
    assign t_ph   = cnt_q[Lb+1];
    assign rot    = s_ph & t_ph;

    generate
        if (Lb > 0) begin : g_ptr
            assign ptr = cnt_q[Lb-1:0];
        end else begin : g_ptr_const
            assign ptr = '0;
        end
    endgenerate

    // Everything is widened by one bit so that -(-2^(W-1)) and the sums stay exact.
    assign a_re_x = {bus_io.a_re[W-1], bus_io.a_re};
    assign a_im_x = {bus_io.a_im[W-1], bus_io.a_im};
    assign m_re_x = {m_re[W-1], m_re};
    assign m_im_x = {m_im[W-1], m_im};
    assign x_re   = rot ? a_im_x : a_re_x;
    assign x_im   = rot ? -a_re_x : a_im_x;
    assign sum_re = x_re + m_re_x;
    assign sum_im = x_im + m_im_x;
    assign dif_re = x_re - m_re_x;
    assign dif_im = x_im - m_im_x;

`ifdef BFII_SCALE_EN
    assign sum_re_r = sum_re[W:1];
    assign sum_im_r = sum_im[W:1];
    assign dif_re_r = dif_re[W:1];
    assign dif_im_r = dif_im[W:1];
`else
    logic unused_msb;
    assign sum_re_r   = sum_re[W-1:0];
    assign sum_im_r   = sum_im[W-1:0];
    assign dif_re_r   = dif_re[W-1:0];
    assign dif_im_r   = dif_im[W-1:0];
    assign unused_msb = ^{sum_re[W], sum_im[W], dif_re[W], dif_im[W]};
`endif

    // Fill phase stores the raw sample; butterfly phase stores the difference.
    assign wr_re  = s_ph ? dif_re_r : bus_io.a_re;
    assign wr_im  = s_ph ? dif_im_r : bus_io.a_im;
    assign out_re = s_ph ? sum_re_r : m_re;
    assign out_im = s_ph ? sum_im_r : m_im;

    fft_delay_line #(
        .DataWidth (W),
        .Depth     (BufSize),
        .PtrW      (PtrW)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .we_i       (accept),
        .ptr_i      (ptr),
        .wdata_re_i (wr_re),
        .wdata_im_i (wr_im),
        .rdata_re_o (m_re),
        .rdata_im_o (m_im)
    );

    always_comb begin
        cnt_d    = cnt_q;
        primed_d = primed_q;
        b_val_d  = b_val_q;
        b_re_d   = b_re_q;
        b_im_d   = b_im_q;
        if (en_i) begin
            if (clr_i) begin
                cnt_d    = '0;
                primed_d = 1'b0;
                b_val_d  = 1'b0;
            end else if (bus_io.in_val) begin
                cnt_d   = cnt_q + CntW'(1);
                b_val_d = primed_q;
                b_re_d  = out_re;
                b_im_d  = out_im;
                if (cnt_q == CntW'(BufSize - 1)) begin
                    primed_d = 1'b1;
                end
            end else begin
                b_val_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            b_val_q  <= 1'b0;
            b_re_q   <= '0;
            b_im_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            b_val_q  <= b_val_d;
            b_re_q   <= b_re_d;
            b_im_q   <= b_im_d;
        end
    end

    assign bus_io.b_val = b_val_q;
    assign bus_io.b_re  = b_re_q;
    assign bus_io.b_im  = b_im_q;

endmodule
